// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//  Shared definitions for the LEGv8 5-stage core: datapath widths, the
//  ALU-op encodings handed to the ALU control decoder, the zero-register
//  index and the decoded control bundle carried down the pipeline.
//
//  Contents
//    DATA_W / OPC_W / REG_AW   operand, opcode-field and register-index widths
//    ALUOP_*                   2-bit alu_op encodings
//    XZR                       register index 31, hard-wired zero
//    ctrl_t                    packed per-instruction control bits
//    mask_ctrl()               zeroes a control bundle for an empty slot
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int OPC_W  = 11;
    localparam int REG_AW = 5;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [REG_AW-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // An empty slot must never carry side-effecting control into EX, so
    // the whole bundle is dropped rather than individual bits.
    function automatic ctrl_t mask_ctrl(input ctrl_t c, input logic valid);
        return valid ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_if
//  Bundle between decode / pipeline control and the ID/EX register.
//
//  Signals
//    id_*      decoded instruction fields presented by the ID stage
//    flush     taken branch resolved downstream, kill ID/EX contents
//    ex_hold   EX cannot accept, freeze ID/EX
//    ex_*      registered copies of the id_* fields driving EX
//    hz_stall  combinational request to hold PC and IF/ID this cycle
//
//  Modports
//    master    decode / hazard-control side (drives id_*, flush, ex_hold)
//    slave     the ID/EX register itself (drives ex_*, hz_stall)
// ---------------------------------------------------------------------------
interface id_ex_stage_reg_if;
    import cpu_pkg::*;

    logic              id_valid;
    logic [OPC_W-1:0]  id_opcode;
    logic [1:0]        id_alu_op;
    logic              id_alu_src;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_reg_write;
    logic              id_mem_to_reg;
    logic              id_branch;
    logic              id_uses_rm;
    logic [DATA_W-1:0] id_rd_data1;
    logic [DATA_W-1:0] id_rd_data2;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic [REG_AW-1:0] id_rd;

    logic              flush;
    logic              ex_hold;

    logic              ex_valid;
    logic [OPC_W-1:0]  ex_opcode;
    logic [1:0]        ex_alu_op;
    logic              ex_alu_src;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              ex_branch;
    logic [DATA_W-1:0] ex_rd_data1;
    logic [DATA_W-1:0] ex_rd_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rn;
    logic [REG_AW-1:0] ex_rm;
    logic [REG_AW-1:0] ex_rd;

    logic              hz_stall;

    modport master (
        output id_valid, id_opcode, id_alu_op, id_alu_src, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_branch,
               id_uses_rm, id_rd_data1, id_rd_data2, id_imm,
               id_rn, id_rm, id_rd, flush, ex_hold,
        input  ex_valid, ex_opcode, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch,
               ex_rd_data1, ex_rd_data2, ex_imm, ex_rn, ex_rm, ex_rd,
               hz_stall
    );

    modport slave (
        input  id_valid, id_opcode, id_alu_op, id_alu_src, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_branch,
               id_uses_rm, id_rd_data1, id_rd_data2, id_imm,
               id_rn, id_rm, id_rd, flush, ex_hold,
        output ex_valid, ex_opcode, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch,
               ex_rd_data1, ex_rd_data2, ex_imm, ex_rn, ex_rm, ex_rd,
               hz_stall
    );

endinterface

// File: rtl/id_ex_hazard.sv
// ---------------------------------------------------------------------------
// id_ex_hazard
//  Combinational load-use detector. Flags the case where the instruction
//  in EX is a load whose destination is read by the instruction in decode;
//  the load data is not available for forwarding until after MEM, so one
//  bubble is needed.
//
//  Configuration macro: HAZARD_DETECT_EN
//    defined   : detection active
//    undefined : hazard tied low, load-use gaps are the compiler's job
//
//  Ports
//    ex_valid, ex_mem_read, ex_rd   in   state of the load in EX
//    id_valid, id_rn, id_rm         in   decode slot and its source indices
//    id_uses_rm                     in   decode instruction actually reads Rm
//    hazard                         out  load-use dependency this cycle
// ---------------------------------------------------------------------------
module id_ex_hazard
    import cpu_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_uses_rm,
    output logic              hazard
);

`ifdef HAZARD_DETECT_EN
    // A load into XZR writes nothing, so it can never feed a dependent.
    // Rm only matters for instructions that really read it (ADDI etc.
    // carry an immediate in that field).
    assign hazard = ex_valid & ex_mem_read & (ex_rd != XZR) & id_valid &
                    ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
`else
    logic unused_hz_inputs;
    assign unused_hz_inputs = ^{ex_valid, ex_mem_read, ex_rd, id_valid,
                                id_rn, id_rm, id_uses_rm};
    assign hazard = 1'b0;
`endif

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//  ID/EX pipeline register of the 5-stage LEGv8 core. Latches decoded
//  control, operands and register indices, drives EX (including
//  opcode + alu_op into ALU control) and owns bubble insertion, flush,
//  hold and the upstream stall request.
//
//  Configuration macro: HAZARD_DETECT_EN (load-use detection in
//  id_ex_hazard). Without it hz_stall only reflects ex_hold.
//
//  Ports
//    clk      in     core clock, rising edge
//    reset_n  in     asynchronous active-low reset
//    bus      slave  id_* / flush / ex_hold in, ex_* / hz_stall out
//
//  Update priority each edge: flush > ex_hold > load-use bubble > load.
// ---------------------------------------------------------------------------
module id_ex_stage_reg
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    id_ex_stage_reg_if.slave bus
);

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl;
    logic              ex_valid;
    logic [OPC_W-1:0]  ex_opcode;
    logic [DATA_W-1:0] ex_rd_data1;
    logic [DATA_W-1:0] ex_rd_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rn;
    logic [REG_AW-1:0] ex_rm;
    logic [REG_AW-1:0] ex_rd;
    logic              hazard;

    assign id_ctrl = '{alu_op:     bus.id_alu_op,
                       alu_src:    bus.id_alu_src,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       reg_write:  bus.id_reg_write,
                       mem_to_reg: bus.id_mem_to_reg,
                       branch:     bus.id_branch};

    id_ex_hazard u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (bus.id_valid),
        .id_rn       (bus.id_rn),
        .id_rm       (bus.id_rm),
        .id_uses_rm  (bus.id_uses_rm),
        .hazard      (hazard)
    );

    // Upstream stall request. A flush discards whatever decode holds, so
    // stalling it would be pointless; a hold must also freeze upstream or
    // the instruction in decode would be overwritten. Held low in reset so
    // the front end is not frozen by stale combinational terms.
    always_comb begin
        bus.hz_stall = 1'b0;
        if (reset_n && !bus.flush) begin
            bus.hz_stall = bus.ex_hold | hazard;
        end
    end

    // Pipeline register. A flush only needs to kill validity and the
    // control bits; stale data is harmless once nothing acts on it. The
    // bubble clears everything so EX sees a clean NOP, and because the
    // bubble has mem_read=0 the stalled instruction loads on the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            ex_opcode   <= '0;
            ex_rd_data1 <= '0;
            ex_rd_data2 <= '0;
            ex_imm      <= '0;
            ex_rn       <= '0;
            ex_rm       <= '0;
            ex_rd       <= '0;
        end else if (bus.flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
        end else if (!bus.ex_hold) begin
            if (hazard) begin
                ex_valid    <= 1'b0;
                ex_ctrl     <= CTRL_NOP;
                ex_opcode   <= '0;
                ex_rd_data1 <= '0;
                ex_rd_data2 <= '0;
                ex_imm      <= '0;
                ex_rn       <= '0;
                ex_rm       <= '0;
                ex_rd       <= '0;
            end else begin
                ex_valid    <= bus.id_valid;
                ex_ctrl     <= mask_ctrl(id_ctrl, bus.id_valid);
                ex_opcode   <= bus.id_opcode;
                ex_rd_data1 <= bus.id_rd_data1;
                ex_rd_data2 <= bus.id_rd_data2;
                ex_imm      <= bus.id_imm;
                ex_rn       <= bus.id_rn;
                ex_rm       <= bus.id_rm;
                ex_rd       <= bus.id_rd;
            end
        end
    end

    assign bus.ex_valid      = ex_valid;
    assign bus.ex_opcode     = ex_opcode;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
    assign bus.ex_alu_src    = ex_ctrl.alu_src;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_branch     = ex_ctrl.branch;
    assign bus.ex_rd_data1   = ex_rd_data1;
    assign bus.ex_rd_data2   = ex_rd_data2;
    assign bus.ex_imm        = ex_imm;
    assign bus.ex_rn         = ex_rn;
    assign bus.ex_rm         = ex_rm;
    assign bus.ex_rd         = ex_rd;

endmodule
